// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
// Shared constants for the five-stage MIPS core: multiply/divide latencies,
// the reset PC and the SPECIAL-opcode funct codes of the md instructions.
// Also provides a helper that sizes the md busy down-counter.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_defs;

    // Busy cycles following a mult/multu or div/divu start
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // md instructions all live under the SPECIAL opcode
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // Width of a down-counter that must hold the longest busy sequence
    function automatic int rem_width(input int div_cycles);
        return $clog2(div_cycles + 1);
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// -----------------------------------------------------------------------------
// md_busy_timer
// Tracks how many cycles the multiply/divide unit remains busy after a start.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset, clears the counter
//   start   in   E-stage md operation starting this cycle
//   is_div  in   qualifies start: 1 = div/divu, 0 = mult/multu
//   busy    out  registered, high while the remaining-cycle count is non-zero
// -----------------------------------------------------------------------------
module md_busy_timer
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    // Counter is sized for DIV_CYCLES; MULT_CYCLES is assumed not to exceed it.
    localparam int REM_W = rem_width(DIV_CYCLES);

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_next;

    // A start while already busy cannot occur in a legal pipeline; it is
    // simply ignored and the running sequence keeps counting down.
    always_comb begin
        rem_next = rem;
        if (start && (rem == '0)) begin
            rem_next = is_div ? REM_W'(DIV_CYCLES) : REM_W'(MULT_CYCLES);
        end else if (rem != '0) begin
            rem_next = rem - REM_W'(1);
        end
    end

    // busy is registered alongside rem so it always equals (rem != 0)
    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            busy <= 1'b0;
        end else begin
            rem  <= rem_next;
            busy <= (rem_next != '0);
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Pipeline stall controller: merges the D-stage data-hazard stall with the
// multiply/divide busy window, drives PC / F/D write enables and the D/E
// flush, and counts stalled cycles for debug.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   hazard_stall  in   combinational data-hazard stall request
//   d_is_md       in   D-stage instruction uses the md unit or HI/LO
//   e_md_start    in   E-stage instruction starts a mult/div this cycle
//   e_md_is_div   in   qualifies e_md_start: 1 = div, 0 = mult
//   pc_we         out  PC register write enable
//   fd_we         out  F/D register write enable
//   de_flush      out  D/E register clear (bubble insert)
//   md_busy       out  md unit busy (registered)
//   stall_cnt     out  stalled cycles since reset, wraps
// -----------------------------------------------------------------------------
module stall_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             d_is_md,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    output logic             pc_we,
    output logic             fd_we,
    output logic             de_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic md_stall;
    logic stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy)
    );

    // The start cycle itself must stall an md consumer: md_busy only rises
    // on the following edge.
    assign md_stall = d_is_md & (e_md_start | md_busy);
    assign stall    = hazard_stall | md_stall;

    // Reset holds the front end frozen and keeps bubbles flowing into E.
    assign pc_we    = ~reset & ~stall;
    assign fd_we    = ~reset & ~stall;
    assign de_flush =  reset |  stall;

    // Both stall sources in one cycle count once.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall controller for the five-stage MIPS core. It owns the write-enable of the fetch-stage PC register and the F/D pipeline register, and the flush of the D/E register. It merges the combinational data-hazard stall with a multi-cycle multiply/divide busy sequence. It also keeps a stall-cycle counter for debug.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles following a mult/multu start
- DIV_CYCLES, 10, busy cycles following a div/divu start
- CNT_W, 32, width of the stall-cycle counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising edge while high
- hazard_stall  input  1  data-hazard stall request from the D-stage hazard comparator (combinational)
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- e_md_start  input  1  E-stage instruction is starting a mult or div this cycle
- e_md_is_div  input  1  qualifies e_md_start: 1 = div/divu, 0 = mult/multu
- pc_we  output  1  write enable of the PC register
- fd_we  output  1  write enable of the F/D register
- de_flush  output  1  clear D/E register (insert bubble)
- md_busy  output  1  multiply/divide unit busy (registered)
- stall_cnt  output  CNT_W  number of cycles stalled since reset

## Operation
- Busy counter `rem` is a down-counter of width clog2(DIV_CYCLES+1).
  - On an edge with e_md_start=1 and rem==0: load DIV_CYCLES if e_md_is_div, else MULT_CYCLES.
  - Otherwise, when rem!=0: decrement by 1.
- md_busy = (rem != 0), taken directly from the register.
- e_md_start while rem!=0 is ignored: no reload, counter keeps decrementing. The pipeline cannot legally produce this; the bench flags it as an error.
- md_stall = d_is_md & (e_md_start | md_busy).
- stall = hazard_stall | md_stall.
- Stall and flush outputs (combinational):
  - pc_we = ~stall
  - fd_we = ~stall
  - de_flush = stall
- While reset is high, all three outputs are forced: pc_we=0, fd_we=0, de_flush=1.
- stall_cnt:
  - Increments by 1 on each non-reset edge where stall=1.
  - Wraps from all-ones to 0.
- hazard_stall and md_stall together count as one stall cycle: a single increment.

## Timing
- Reset values: rem=0, md_busy=0, stall_cnt=0.
- Stall outputs respond in the same cycle as their inputs: zero latency, no registers in the path.
- Busy window: start at edge T (start seen during cycle T-1). md_busy is high during exactly N cycles after that edge, then falls.
  - N = MULT_CYCLES or DIV_CYCLES.
- A d_is_md instruction paired with the start cycle itself stalls: e_md_start is high that cycle.
- Total md stall for an md-dependent instruction directly behind the start is N+1 cycles.
- At the last busy cycle (rem==1): md_busy=1, so a stall is still asserted. In the next cycle md_busy=0 and the instruction proceeds.
- Back-to-back start is allowed once rem==0. A start in the same cycle rem reaches 0 reloads.
- Reset mid-operation: rem and md_busy clear at that edge, and stall_cnt clears. The next cycle has no stall unless hazard_stall=1.

## Structure
- Shared package `mips_defs`: MULT_CYCLES, DIV_CYCLES, reset PC 32'h0000_3000, md opcode/funct constants.
- stall_ctrl computes only counts and enables. d_is_md is decoded upstream.
- One natural sub-module: `md_busy_timer`, containing rem, the load/decrement logic and md_busy. stall_ctrl wraps it with the stall combine and stall_cnt.

## Test plan
- Reset held 2 cycles, then all inputs 0:
  - during reset: pc_we=0, fd_we=0, de_flush=1
  - after reset: pc_we=1, fd_we=1, de_flush=0, md_busy=0, stall_cnt=0
- hazard_stall=1 for 3 cycles: pc_we=fd_we=0 and de_flush=1 for exactly those 3 cycles; stall_cnt=3.
- mult start (e_md_start=1, is_div=0) for one cycle, d_is_md=0 throughout:
  - md_busy high for exactly 5 cycles, pc_we stays 1
  - repeat with div: busy for exactly 10 cycles
- div start with d_is_md=1 held: pc_we=0 for 11 consecutive cycles (start cycle + 10), pc_we=1 in the 12th; stall_cnt=11.
- Overlap: hazard_stall=1 and md stall active in the same 4 cycles: stall_cnt increments by 4, not 8.
- Reset asserted when rem=6 during a div: next cycle md_busy=0, stall_cnt=0, pc_we=1 with d_is_md=1.
